// File: rtl/ram_write_sequencer_pkg.sv
// Shared definitions for the memory-side sequencers: FSM state encodings.
package ram_write_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_BURST = 2'd2
   } seq_state_e;

endpackage

// File: rtl/ram_write_sequencer.sv
// Drives a single-port RAM: a whole-array fill with FILL_VALUE, or a streamed burst write
// starting at a given address. All RAM-side outputs are registered.
module ram_write_sequencer
   import ram_write_sequencer_pkg::*;
#(
   parameter int unsigned          ADDRWIDTH  = 8,
   parameter int unsigned          DATAWIDTH  = 4,
   parameter logic [DATAWIDTH-1:0] FILL_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_clear,
   input  logic [ADDRWIDTH-1:0] cmd_addr,
   input  logic [ADDRWIDTH-1:0] cmd_len,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DATAWIDTH-1:0] s_data,
   output logic                 ram_we,
   output logic [ADDRWIDTH-1:0] ram_a,
   output logic [DATAWIDTH-1:0] ram_di,
   output logic                 busy,
   output logic                 done
);

   seq_state_e           r_state;
   seq_state_e           w_state_nxt;
   logic [ADDRWIDTH-1:0] r_addr;
   logic [ADDRWIDTH-1:0] r_cnt;
   logic                 w_accept;
   logic                 w_fire;
   logic                 w_last;
   logic                 r_we;
   logic                 r_done;
   logic [ADDRWIDTH-1:0] r_a;
   logic [DATAWIDTH-1:0] r_di;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      cmd_ready   = 1'b0;
      s_ready     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_nxt = cmd_clear ? ST_CLEAR : ST_BURST;
            end
         end
         ST_CLEAR: begin
            w_fire = 1'b1;
         end
         ST_BURST: begin
            s_ready = 1'b1;
            w_fire  = s_valid;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_accept = cmd_ready && cmd_valid;
      // r_cnt holds beats remaining minus one, so zero marks the final write
      w_last   = w_fire && (r_cnt == '0);
      if (w_last) begin
         w_state_nxt = ST_IDLE;
      end
   end

   // A clear is just a full-depth burst from address 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_addr <= cmd_clear ? '0 : cmd_addr;
         r_cnt  <= cmd_clear ? '1 : cmd_len;
      end else if (w_fire) begin
         r_addr <= r_addr + ADDRWIDTH'(1);
         r_cnt  <= r_cnt - ADDRWIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         r_a    <= '0;
         r_di   <= '0;
      end else begin
         r_we   <= w_fire;
         r_done <= w_last;
         if (w_fire) begin
            r_a  <= r_addr;
            r_di <= (r_state == ST_CLEAR) ? FILL_VALUE : s_data;
         end
      end
   end

   assign ram_we = r_we;
   assign ram_a  = r_a;
   assign ram_di = r_di;
   assign done   = r_done;
   assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Self-checking bench: every expected RAM write (address, data, done, cycle) is queued when
// stimulus is driven and checked by a monitor when ram_we appears.
module tb_ram_write_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_clear = 1'b0;
   logic [7:0] cmd_addr = '0;
   logic [7:0] cmd_len = '0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [3:0] s_data = '0;
   logic       ram_we;
   logic [7:0] ram_a;
   logic [3:0] ram_di;
   logic       busy;
   logic       done;

   typedef struct {
      logic [7:0] addr;
      logic [3:0] data;
      logic       last;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic [7:0] last_a = '0;
   logic [3:0] last_di = '0;

   ram_write_sequencer #(
      .ADDRWIDTH (8),
      .DATAWIDTH (4),
      .FILL_VALUE(4'h0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_clear(cmd_clear),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .ram_we   (ram_we),
      .ram_a    (ram_a),
      .ram_di   (ram_di),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: pops the scoreboard on every ram_we, otherwise checks hold and done=0
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         last_a  = '0;
         last_di = '0;
      end else if (ram_we) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h cycle=%0d, required no write",
                     ram_a, ram_di, cyc);
         end else begin
            e = sb.pop_front();
            if (ram_a !== e.addr || ram_di !== e.data || done !== e.last || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL write: got addr=%0h data=%0h done=%0b cycle=%0d, required addr=%0h data=%0h done=%0b cycle=%0d",
                        ram_a, ram_di, done, cyc, e.addr, e.data, e.last, e.cyc);
            end
         end
         last_a  = ram_a;
         last_di = ram_di;
      end else begin
         n_checks++;
         if (done !== 1'b0 || ram_a !== last_a || ram_di !== last_di) begin
            n_fail++;
            $display("FAIL idle_hold: got done=%0b addr=%0h data=%0h, required done=0 addr=%0h data=%0h",
                     done, ram_a, ram_di, last_a, last_di);
         end
      end
   end

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if (cmd_ready !== 1'b1 || s_ready !== 1'b0 || ram_we !== 1'b0 || ram_a !== 8'h00 ||
          ram_di !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got rdy=%0b srdy=%0b we=%0b a=%0h di=%0h busy=%0b done=%0b, required 1 0 0 0 0 0 0",
                  cmd_ready, s_ready, ram_we, ram_a, ram_di, busy, done);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_clear();
      bit ok;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_clear = 1'b1; cmd_addr = 8'h55; cmd_len = 8'h03;
      for (int i = 0; i < 256; i++)
         sb.push_back('{addr: 8'(i), data: 4'h0, last: (i == 255), cyc: cyc + 2 + i});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0 || s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_flags: got busy=%0b rdy=%0b srdy=%0b, required 1 0 0", busy, cmd_ready, s_ready);
      end
      repeat (40) @(posedge clk); #1;
      // Stray command and data beat mid-clear must both be ignored
      cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_addr = 8'h33; cmd_len = 8'h00;
      s_valid = 1'b1; s_data = 4'h7;
      n_checks++;
      if (cmd_ready !== 1'b0 || s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_ignore_cmd: got rdy=%0b srdy=%0b, required 0 0", cmd_ready, s_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; s_valid = 1'b0;
      wait_drain(400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL clear_drain: got %0d writes pending, required 0", sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_end: got busy=%0b rdy=%0b, required 0 1", busy, cmd_ready);
      end
      repeat (5) @(posedge clk);
   endtask

   task automatic test_burst_basic();
      bit ok;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_addr = 8'h10; cmd_len = 8'd3;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; s_valid = 1'b1; s_data = 4'(i + 1);
         sb.push_back('{addr: 8'(8'h10 + i), data: 4'(i + 1), last: (i == 3), cyc: cyc + 1});
         n_checks++;
         if (s_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_flags: got srdy=%0b busy=%0b rdy=%0b, required 1 1 0", s_ready, busy, cmd_ready);
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      n_checks++;
      if (s_ready !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL burst_end: got srdy=%0b rdy=%0b busy=%0b done=%0b, required 0 1 0 1",
                  s_ready, cmd_ready, busy, done);
      end
      wait_drain(20, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL burst_drain: got %0d writes pending, required 0", sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_burst_wrap_gaps();
      bit         ok;
      logic [4:0] pat;
      logic [7:0] ea;
      int         k;
      pat = 5'b10101;
      ea  = 8'hFE;
      k   = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_addr = 8'hFE; cmd_len = 8'd2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; s_valid = pat[i];
         if (pat[i]) begin
            s_data = 4'(4'hA + k);
            sb.push_back('{addr: ea, data: 4'(4'hA + k), last: (k == 2), cyc: cyc + 1});
            ea = ea + 8'd1;
            k++;
         end else begin
            s_data = 4'hF;
         end
         n_checks++;
         if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_s_ready: got %0b, required 1 (step %0d)", s_ready, i);
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      n_checks++;
      if (s_ready !== 1'b0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_end: got srdy=%0b done=%0b, required 0 1", s_ready, done);
      end
      wait_drain(20, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wrap_drain: got %0d writes pending, required 0", sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset_mid_burst();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_addr = 8'h40; cmd_len = 8'd7;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; s_valid = 1'b1; s_data = 4'(8 + i);
         if (i < 2) sb.push_back('{addr: 8'(8'h40 + i), data: 4'(8 + i), last: 1'b0, cyc: cyc + 1});
      end
      @(negedge clk); #1;
      rst_n = 1'b0; s_valid = 1'b0;
      #1;
      n_checks++;
      if (ram_we !== 1'b0 || cmd_ready !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || ram_a !== 8'h00 || ram_di !== 4'h0) begin
         n_fail++;
         $display("FAIL mid_reset: got we=%0b rdy=%0b srdy=%0b busy=%0b done=%0b a=%0h di=%0h, required 0 1 0 0 0 0 0",
                  ram_we, cmd_ready, s_ready, busy, done, ram_a, ram_di);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_after: got pending=%0d busy=%0b, required 0 0", sb.size(), busy);
         sb.delete();
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      // First command right after reset release must be taken on its first edge
      #5 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_addr = 8'h80; cmd_len = 8'd1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; s_valid = 1'b1; s_data = 4'(3 + i);
         sb.push_back('{addr: 8'(8'h80 + i), data: 4'(3 + i), last: (i == 1), cyc: cyc + 1});
      end
      @(posedge clk); #1;
      s_valid = 1'b0; cmd_valid = 1'b1; cmd_addr = 8'h20; cmd_len = 8'd2;
      n_checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept_in_done: got rdy=%0b done=%0b, required 1 1", cmd_ready, done);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; s_valid = 1'b1; s_data = 4'(4'hC + i);
         sb.push_back('{addr: 8'(8'h20 + i), data: 4'(4'hC + i), last: (i == 2), cyc: cyc + 1});
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      wait_drain(20, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL b2b_drain: got %0d writes pending, required 0", sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_clear();
      test_burst_basic();
      test_burst_wrap_gaps();
      test_reset_mid_burst();
      test_back_to_back();
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_write_sequencer.md
RAM_WRITE_SEQUENCER -- requirements
Module: ram_write_sequencer

Interface
REQ-001 Parameter ADDRWIDTH, default 8: RAM address width; RAM depth is 2**ADDRWIDTH.
REQ-002 Parameter DATAWIDTH, default 4: RAM word width.
REQ-003 Parameter FILL_VALUE, default 0: word written to every address by a clear command.
REQ-004 Port clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port cmd_valid  input  1: command offered.
REQ-007 Port cmd_ready  output  1: sequencer accepts a command.
REQ-008 Port cmd_clear  input  1: 1 = clear whole RAM, 0 = burst write.
REQ-009 Port cmd_addr  input  ADDRWIDTH: burst start address.
REQ-010 Port cmd_len  input  ADDRWIDTH: burst beats minus one, so 1..2**ADDRWIDTH beats.
REQ-011 Port s_valid  input  1: write-data beat offered.
REQ-012 Port s_ready  output  1: beat accepted.
REQ-013 Port s_data  input  DATAWIDTH: write-data beat.
REQ-014 Port ram_we  output  1: write enable to the single-port RAM.
REQ-015 Port ram_a  output  ADDRWIDTH: RAM address.
REQ-016 Port ram_di  output  DATAWIDTH: RAM write data.
REQ-017 Port busy  output  1: high whenever the state is not IDLE.
REQ-018 Port done  output  1: one-cycle pulse on the final write of a command.

Function
REQ-019 The block SHALL implement the states IDLE, CLEAR and BURST.
REQ-020 In IDLE, cmd_ready SHALL be 1, s_ready SHALL be 0, and cmd_valid=1 SHALL accept a command in that cycle.
REQ-021 On accept, the block SHALL latch cmd_addr and cmd_len, then enter CLEAR if cmd_clear=1, otherwise BURST.
REQ-022 In CLEAR, the block SHALL write FILL_VALUE to addresses 0 through 2**ADDRWIDTH-1, one per cycle, ignore cmd_addr/cmd_len, hold s_ready=0, and return to IDLE after address 2**ADDRWIDTH-1.
REQ-023 In BURST, s_ready SHALL be 1, and each cycle with s_valid=1 SHALL write s_data to the current address, increment the address and decrement the remaining count.
REQ-024 A cycle in BURST with s_valid=0 SHALL cause no write and no address advance.
REQ-025 The BURST address SHALL wrap modulo 2**ADDRWIDTH (for example 0xFF+1 -> 0x00 when ADDRWIDTH=8).
REQ-026 After cmd_len+1 beats, the block SHALL return to IDLE in the cycle after the last beat is accepted, and s_ready SHALL be 0 in that cycle.
REQ-027 ram_we, ram_a and ram_di SHALL be registered: a write accepted (BURST) or issued (CLEAR) in cycle N SHALL appear on these ports in cycle N+1.
REQ-028 ram_we SHALL be 0 in every other cycle.
REQ-029 ram_a and ram_di SHALL hold their last values when ram_we=0.
REQ-030 done SHALL be 1 in exactly the cycle in which the final ram_we of a command is 1, and 0 otherwise.
REQ-031 cmd_ready SHALL be 0 outside IDLE, and cmd_valid outside IDLE SHALL be ignored.
REQ-032 A command with cmd_len=2**ADDRWIDTH-1 SHALL write every address exactly once, starting at cmd_addr.
REQ-033 Back-to-back commands SHALL be legal: a new command SHALL be accepted in the cycle in which done=1.

Reset
REQ-034 While rst_n=0, the block SHALL force state=IDLE and the following values, asynchronously: cmd_ready=1, s_ready=0, ram_we=0, ram_a=0, ram_di=0, busy=0, done=0, internal address=0 and internal count=0.
REQ-035 Reset asserted mid-CLEAR or mid-BURST SHALL abandon the command with no further write, and ram_we SHALL fall in the same cycle as reset.
REQ-036 The first command after reset deassertion SHALL be accepted on the first rising edge with cmd_valid=1.

Structure
REQ-037 The state encodings (ST_IDLE, ST_CLEAR, ST_BURST) SHALL reside in the shared include/package used by the memory blocks.
REQ-038 No sub-module SHALL be instantiated: the block SHALL be one FSM with one address counter and one beat counter.
REQ-039 The RAM SHALL be instantiated by the parent and driven via ram_we, ram_a and ram_di.

Verification
REQ-040 Reset, then clear (ADDRWIDTH=8, FILL_VALUE=0) -> exactly 256 ram_we pulses at addresses 0..255 with ram_di=0, done on address 255, busy=0 the next cycle.
REQ-041 Burst with cmd_addr=0x10, cmd_len=3 and data 1,2,3,4 streamed without gaps -> writes 0x10..0x13 = 1,2,3,4 one cycle after each accept; done with the write of 4.
REQ-042 Burst with cmd_addr=0xFE, cmd_len=2, where s_valid toggles 1,0,1,0,1 -> writes 0xFE, 0xFF, 0x00 only on accepted beats; no write on gap cycles.
REQ-043 Reset pulsed during the third beat of a cmd_len=7 burst -> ram_we=0 immediately, state IDLE, cmd_ready=1, and no further writes.
REQ-044 Second command presented in the done cycle of the first -> accepted in that cycle with no idle cycle between the two commands' writes.
REQ-045 cmd_valid pulsed during CLEAR -> ignored: writes remain 0..255 and no extra command is executed.
